// File: rtl/ex_stage_if.sv
// ID/EX -> EX and EX -> EX/MEM signal bundle for the execute stage.
// slave: the execute stage (consumes id_ex_*, drives ex_mem_*).
// master: whatever drives the stage (ID/EX register, or a testbench).
interface ex_stage_if;
    // ID/EX pipeline register contents
    logic [31:0] id_ex_reg_a_data;
    logic [31:0] id_ex_reg_b_data;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_shamt;
    logic [31:0] id_ex_pc_plus4;
    logic [25:0] id_ex_jump_target;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src;
    logic [2:0]  id_ex_md_op;
    logic        id_ex_ctrl_branch;
    logic [2:0]  id_ex_ctrl_branch_type;
    logic        id_ex_ctrl_jump;
    logic        id_ex_ctrl_jump_reg;
    logic [2:0]  id_ex_ctrl_load_type;
    logic        id_ex_ctrl_mem_to_reg;
    logic        id_ex_ctrl_mem_write;
    logic        id_ex_ctrl_reg_write;
    logic [1:0]  id_ex_ctrl_store_type;
    logic [4:0]  id_ex_rd;

    // EX/MEM pipeline register contents
    logic        ex_mem_ctrl_branch;
    logic [2:0]  ex_mem_ctrl_branch_type;
    logic        ex_mem_ctrl_jump;
    logic        ex_mem_ctrl_jump_reg;
    logic [2:0]  ex_mem_ctrl_load_type;
    logic        ex_mem_ctrl_mem_to_reg;
    logic        ex_mem_ctrl_mem_write;
    logic        ex_mem_ctrl_reg_write;
    logic [1:0]  ex_mem_ctrl_store_type;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_alu_out;
    logic [31:0] ex_mem_reg_b_data;
    logic [31:0] ex_mem_pc_branch;
    logic [31:0] ex_mem_pc_jump;
    logic        ex_mem_alu_beq_sig;
    logic        ex_mem_alu_bne_sig;
    logic        ex_mem_alu_bgez_sig;
    logic        ex_mem_alu_bgtz_sig;
    logic        ex_mem_alu_blez_sig;
    logic        ex_mem_alu_bltz_sig;

    modport slave (
        input  id_ex_reg_a_data, id_ex_reg_b_data, id_ex_imm, id_ex_shamt,
               id_ex_pc_plus4, id_ex_jump_target, id_ex_alu_op, id_ex_alu_src,
               id_ex_md_op, id_ex_ctrl_branch, id_ex_ctrl_branch_type,
               id_ex_ctrl_jump, id_ex_ctrl_jump_reg, id_ex_ctrl_load_type,
               id_ex_ctrl_mem_to_reg, id_ex_ctrl_mem_write, id_ex_ctrl_reg_write,
               id_ex_ctrl_store_type, id_ex_rd,
        output ex_mem_ctrl_branch, ex_mem_ctrl_branch_type, ex_mem_ctrl_jump,
               ex_mem_ctrl_jump_reg, ex_mem_ctrl_load_type, ex_mem_ctrl_mem_to_reg,
               ex_mem_ctrl_mem_write, ex_mem_ctrl_reg_write, ex_mem_ctrl_store_type,
               ex_mem_rd, ex_mem_alu_out, ex_mem_reg_b_data, ex_mem_pc_branch,
               ex_mem_pc_jump, ex_mem_alu_beq_sig, ex_mem_alu_bne_sig,
               ex_mem_alu_bgez_sig, ex_mem_alu_bgtz_sig, ex_mem_alu_blez_sig,
               ex_mem_alu_bltz_sig
    );

    modport master (
        output id_ex_reg_a_data, id_ex_reg_b_data, id_ex_imm, id_ex_shamt,
               id_ex_pc_plus4, id_ex_jump_target, id_ex_alu_op, id_ex_alu_src,
               id_ex_md_op, id_ex_ctrl_branch, id_ex_ctrl_branch_type,
               id_ex_ctrl_jump, id_ex_ctrl_jump_reg, id_ex_ctrl_load_type,
               id_ex_ctrl_mem_to_reg, id_ex_ctrl_mem_write, id_ex_ctrl_reg_write,
               id_ex_ctrl_store_type, id_ex_rd,
        input  ex_mem_ctrl_branch, ex_mem_ctrl_branch_type, ex_mem_ctrl_jump,
               ex_mem_ctrl_jump_reg, ex_mem_ctrl_load_type, ex_mem_ctrl_mem_to_reg,
               ex_mem_ctrl_mem_write, ex_mem_ctrl_reg_write, ex_mem_ctrl_store_type,
               ex_mem_rd, ex_mem_alu_out, ex_mem_reg_b_data, ex_mem_pc_branch,
               ex_mem_pc_jump, ex_mem_alu_beq_sig, ex_mem_alu_bne_sig,
               ex_mem_alu_bgez_sig, ex_mem_alu_bgtz_sig, ex_mem_alu_blez_sig,
               ex_mem_alu_bltz_sig
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch conditions, branch/jump targets, HI/LO with
// single-cycle multiply and an iterative restoring divider that stalls the
// front end while it runs. Drives the EX/MEM pipeline register.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    output logic       ex_stall,
    ex_stage_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} div_state_t;

    div_state_t  r_state, w_state_next;
    logic [4:0]  r_count;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_rem, r_quot, r_divisor, r_dividend_raw;
    logic        r_neg_q, r_neg_r, r_div_zero;

    logic [31:0] w_a, w_b, w_op_b, w_alu_out;
    logic [31:0] w_pc_branch, w_pc_jump;
    logic        w_beq, w_bne, w_bgez, w_bgtz, w_blez, w_bltz;
    logic [63:0] w_mult_s, w_mult_u;
    logic        w_is_div, w_stall, w_bubble;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_shift, w_sub;
    logic        w_fit, w_div_last;
    logic [31:0] w_rem_step, w_quot_step, w_q_final, w_r_final;

    assign w_a    = bus.id_ex_reg_a_data;
    assign w_b    = bus.id_ex_reg_b_data;
    assign w_op_b = bus.id_ex_alu_src ? bus.id_ex_imm : w_b;

    // ALU result selection
    always_comb begin
        w_alu_out = '0;
        case (bus.id_ex_alu_op)
            4'd0:  w_alu_out = w_a + w_op_b;
            4'd1:  w_alu_out = w_a - w_op_b;
            4'd2:  w_alu_out = w_a & w_op_b;
            4'd3:  w_alu_out = w_a | w_op_b;
            4'd4:  w_alu_out = w_a ^ w_op_b;
            4'd5:  w_alu_out = ~(w_a | w_op_b);
            4'd6:  w_alu_out = {31'b0, $signed(w_a) < $signed(w_op_b)};
            4'd7:  w_alu_out = {31'b0, w_a < w_op_b};
            4'd8:  w_alu_out = w_op_b << bus.id_ex_shamt;
            4'd9:  w_alu_out = w_op_b >> bus.id_ex_shamt;
            4'd10: w_alu_out = $unsigned($signed(w_op_b) >>> bus.id_ex_shamt);
            4'd11: w_alu_out = {bus.id_ex_imm[15:0], 16'b0};
            4'd12: w_alu_out = r_hi;
            4'd13: w_alu_out = r_lo;
            default: w_alu_out = '0;
        endcase
    end

    // Branch conditions look only at the register operands, never at imm
    assign w_beq  = (w_a == w_b);
    assign w_bne  = (w_a != w_b);
    assign w_bgez = ~w_a[31];
    assign w_bltz = w_a[31];
    assign w_bgtz = ~w_a[31] & (|w_a);
    assign w_blez = w_a[31] | ~(|w_a);

    assign w_pc_branch = bus.id_ex_pc_plus4 + {bus.id_ex_imm[29:0], 2'b00};
    assign w_pc_jump   = bus.id_ex_ctrl_jump_reg ? w_a
                       : {bus.id_ex_pc_plus4[31:28], bus.id_ex_jump_target, 2'b00};

    // Low 64 bits of an extended product equal the signed 64-bit product
    assign w_mult_s = {{32{w_a[31]}}, w_a} * {{32{w_b[31]}}, w_b};
    assign w_mult_u = {32'b0, w_a} * {32'b0, w_b};

    // Divider operand preparation: work on magnitudes, fix signs at the end
    assign w_is_div = (bus.id_ex_md_op == 3'd3) || (bus.id_ex_md_op == 3'd4);
    assign w_a_neg  = (bus.id_ex_md_op == 3'd3) & w_a[31];
    assign w_b_neg  = (bus.id_ex_md_op == 3'd3) & w_b[31];
    assign w_a_mag  = w_a_neg ? -w_a : w_a;
    assign w_b_mag  = w_b_neg ? -w_b : w_b;

    // One restoring step: shift in next dividend bit, subtract if it fits
    assign w_shift     = {r_rem, r_quot[31]};
    assign w_sub       = w_shift - {1'b0, r_divisor};
    assign w_fit       = ~w_sub[32];
    assign w_rem_step  = w_fit ? w_sub[31:0] : w_shift[31:0];
    assign w_quot_step = {r_quot[30:0], w_fit};
    assign w_q_final   = r_neg_q ? -w_quot_step : w_quot_step;
    assign w_r_final   = r_neg_r ? -w_rem_step : w_rem_step;
    assign w_div_last  = (r_count == 5'(DIV_CYCLES - 1));

    // Divider next-state and stall generation; flush always wins
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_div && !flush) begin
                    w_stall      = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (w_div_last) w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Stall is masked during reset so the front end is released immediately
    assign ex_stall = w_stall & rst_n;
    assign w_bubble = flush | w_stall;

    // Divider state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Divider datapath: latch operands on start, iterate while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count        <= '0;
            r_rem          <= '0;
            r_quot         <= '0;
            r_divisor      <= '0;
            r_dividend_raw <= '0;
            r_neg_q        <= 1'b0;
            r_neg_r        <= 1'b0;
            r_div_zero     <= 1'b0;
        end else if (r_state == S_IDLE && w_is_div && !flush) begin
            r_count        <= '0;
            r_rem          <= '0;
            r_quot         <= w_a_mag;
            r_divisor      <= w_b_mag;
            r_dividend_raw <= w_a;
            r_neg_q        <= w_a_neg ^ w_b_neg;
            r_neg_r        <= w_a_neg;
            r_div_zero     <= (w_b == 32'd0);
        end else if (r_state == S_BUSY && !flush) begin
            r_count <= 5'(r_count + 5'd1);
            r_rem   <= w_rem_step;
            r_quot  <= w_quot_step;
        end
    end

    // HI/LO update from divide completion or from MULT/MULTU/MTHI/MTLO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!flush) begin
            if (r_state == S_BUSY && w_div_last) begin
                if (r_div_zero) begin
                    r_hi <= r_dividend_raw;
                    r_lo <= 32'hFFFF_FFFF;
                end else begin
                    r_hi <= w_r_final;
                    r_lo <= w_q_final;
                end
            end else if (r_state == S_IDLE) begin
                case (bus.id_ex_md_op)
                    3'd1: {r_hi, r_lo} <= w_mult_s;
                    3'd2: {r_hi, r_lo} <= w_mult_u;
                    3'd5: r_hi <= w_a;
                    3'd6: r_lo <= w_a;
                    default: ;
                endcase
            end
        end
    end

    // EX/MEM register: side-effecting controls are cleared on a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_mem_ctrl_branch      <= 1'b0;
            bus.ex_mem_ctrl_branch_type <= '0;
            bus.ex_mem_ctrl_jump        <= 1'b0;
            bus.ex_mem_ctrl_jump_reg    <= 1'b0;
            bus.ex_mem_ctrl_load_type   <= '0;
            bus.ex_mem_ctrl_mem_to_reg  <= 1'b0;
            bus.ex_mem_ctrl_mem_write   <= 1'b0;
            bus.ex_mem_ctrl_reg_write   <= 1'b0;
            bus.ex_mem_ctrl_store_type  <= '0;
            bus.ex_mem_rd               <= '0;
            bus.ex_mem_alu_out          <= '0;
            bus.ex_mem_reg_b_data       <= '0;
            bus.ex_mem_pc_branch        <= '0;
            bus.ex_mem_pc_jump          <= '0;
            bus.ex_mem_alu_beq_sig      <= 1'b0;
            bus.ex_mem_alu_bne_sig      <= 1'b0;
            bus.ex_mem_alu_bgez_sig     <= 1'b0;
            bus.ex_mem_alu_bgtz_sig     <= 1'b0;
            bus.ex_mem_alu_blez_sig     <= 1'b0;
            bus.ex_mem_alu_bltz_sig     <= 1'b0;
        end else begin
            bus.ex_mem_ctrl_branch      <= bus.id_ex_ctrl_branch & ~w_bubble;
            bus.ex_mem_ctrl_branch_type <= bus.id_ex_ctrl_branch_type;
            bus.ex_mem_ctrl_jump        <= bus.id_ex_ctrl_jump & ~w_bubble;
            bus.ex_mem_ctrl_jump_reg    <= bus.id_ex_ctrl_jump_reg & ~w_bubble;
            bus.ex_mem_ctrl_load_type   <= bus.id_ex_ctrl_load_type;
            bus.ex_mem_ctrl_mem_to_reg  <= bus.id_ex_ctrl_mem_to_reg;
            bus.ex_mem_ctrl_mem_write   <= bus.id_ex_ctrl_mem_write & ~w_bubble;
            // A divide never writes the register file, even as it retires
            bus.ex_mem_ctrl_reg_write   <= bus.id_ex_ctrl_reg_write & ~w_bubble & ~w_is_div;
            bus.ex_mem_ctrl_store_type  <= bus.id_ex_ctrl_store_type;
            bus.ex_mem_rd               <= bus.id_ex_rd;
            bus.ex_mem_alu_out          <= w_alu_out;
            bus.ex_mem_reg_b_data       <= w_b;
            bus.ex_mem_pc_branch        <= w_pc_branch;
            bus.ex_mem_pc_jump          <= w_pc_jump;
            bus.ex_mem_alu_beq_sig      <= w_beq;
            bus.ex_mem_alu_bne_sig      <= w_bne;
            bus.ex_mem_alu_bgez_sig     <= w_bgez;
            bus.ex_mem_alu_bgtz_sig     <= w_bgtz;
            bus.ex_mem_alu_blez_sig     <= w_blez;
            bus.ex_mem_alu_bltz_sig     <= w_bltz;
        end
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It sits between the ID/EX register and the MEM stage, and drives the complete ex_mem_* pipeline register that the MEM stage consumes.
- Contains the ALU, the branch-condition generators, and branch/jump target computation.
- Owns the HI/LO registers: single-cycle MULT/MULTU and an iterative 32-cycle DIV/DIVU unit that stalls the front end while busy.

Parameters:
DIV_CYCLES, 32, number of restoring-division iterations; the iteration counter is 5 bits wide.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
flush  in  1  MEM stage branch_taken|jump_taken; squashes the instruction in EX
id_ex_reg_a_data / id_ex_reg_b_data  in  32  forwarded rs / rt operands
id_ex_imm  in  32  sign/zero-extended immediate
id_ex_shamt  in  5  shift amount
id_ex_pc_plus4  in  32  PC+4 of the instruction
id_ex_jump_target  in  26  J-type target field
id_ex_alu_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLTU,8 SLL,9 SRL,10 SRA,11 LUI,12 MFHI,13 MFLO
id_ex_alu_src  in  1  1 = operand B is imm
id_ex_md_op  in  3  0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO
id_ex_ctrl_*  in  -  branch(1), branch_type(3), jump(1), jump_reg(1), load_type(3), mem_to_reg(1), mem_write(1), reg_write(1), store_type(2)
id_ex_rd  in  5  destination register
ex_stall  out  1  hold PC, IF/ID and ID/EX
ex_mem_*  out  -  registered copies of every ctrl field, plus rd(5), alu_out(32), reg_b_data(32), pc_branch(32), pc_jump(32), and alu_beq/bne/bgez/bgtz/blez/bltz_sig(1 each)

Behaviour:
- **Reset:** every ex_mem_* output is 0. HI = LO = 0. Divider FSM goes to IDLE with count = 0. ex_stall = 0.
- **ALU:**
  - Operand B = alu_src ? imm : reg_b_data.
  - ADD/SUB wrap modulo 2^32 with no overflow trap.
  - SLT is signed and SLTU is unsigned; both produce 0 or 1.
  - Shifts use shamt. SRA is arithmetic.
  - LUI gives {imm[15:0], 16'b0}.
  - MFHI/MFLO return the current HI/LO.
- **Branch signals:** computed from reg_a and reg_b only.
  - beq: a == b. bne: a != b.
  - bgez: a[31] == 0. bltz: a[31] == 1.
  - bgtz: signed a > 0. blez: signed a <= 0.
- **Targets:**
  - pc_branch = pc_plus4 + (imm << 2), modulo 2^32.
  - pc_jump = jump_reg ? reg_a : {pc_plus4[31:28], jump_target, 2'b00}.
- **Pipeline register:** ex_mem_* load every non-stalled, non-flushed edge with latency 1.
- **Bubble (flush, or ex_stall high):** at the edge, ex_mem_reg_write, mem_write, branch, jump and jump_reg load 0. The other fields are don't-care and are loaded normally.
- **MULT/MULTU/MTHI/MTLO:** HI/LO are written at the edge ending the EX cycle, unless flush is high. MULT is signed 64-bit and MULTU is unsigned. MTHI/MTLO write reg_a to HI or LO.
- **Divider FSM (IDLE, BUSY, DONE):**
  - IDLE: if md_op is DIV/DIVU and flush = 0, ex_stall = 1 combinationally. At the edge, latch operand magnitudes, signs and the signedness flag, set count = 0, and go to BUSY.
  - BUSY: ex_stall = 1. One restoring iteration per edge, count++.
  - BUSY exit: at the edge where count == DIV_CYCLES-1, write HI = remainder and LO = quotient, then go to DONE.
  - DONE: ex_stall = 0. The DIV instruction retires into EX/MEM with reg_write = 0, then the FSM returns to IDLE.
  - Total EX occupancy is 34 cycles, with ex_stall high for 33.
  - Result signs: quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
  - Divisor = 0: LO = 32'hFFFFFFFF, HI = dividend, for both DIV and DIVU.
  - DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- **Flush and reset mid-operation:**
  - flush while in BUSY or DONE aborts the divide: next state IDLE, HI/LO unchanged, ex_stall drops the same cycle.
  - flush has priority over a new DIV start.
  - rst_n low at any time forces the reset state asynchronously.
- **MFHI/MFLO immediately after DIV** sees the new value, because HI/LO are written before the DONE cycle.

Test Plan:
- **ALU and branch signals:** ADD 0x7FFFFFFF + 1 → ex_mem_alu_out = 0x80000000 after 1 edge. SLT a = -1, b = 1 → 1. SLTU with the same operands → 0. SRA 0x80000000 by 4 → 0xF8000000. With a = 0, b = 0: beq = 1, bgez = 1, blez = 1, bgtz = 0.
- **Targets:** pc_plus4 = 0x00400010, imm = 0xFFFFFFFF → pc_branch = 0x0040000C. J with target 0x0100000 → pc_jump = 0x00400000. jump_reg with a = 0x1234 → pc_jump = 0x1234.
- **Signed DIV:** DIV -7 / 2 → ex_stall high for exactly 33 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. A following MFLO gives alu_out = 0xFFFFFFFD.
- **Divide corner cases:** DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. MULT -2 × 3 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- **Flush:** flush raised on cycle 10 of a DIV → ex_stall low that cycle, FSM in IDLE next cycle, HI/LO unchanged. flush with an ADD reg_write = 1 → ex_mem_ctrl_reg_write = 0.
- **Reset:** rst_n pulled low mid-BUSY → all outputs 0, ex_stall = 0, and HI = LO = 0 immediately without a clock.
